// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-requester round-robin arbiter.
// Contents: requester count, index and hold-counter widths, FSM state enum.
package arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the clients and rr_arbiter8.
// Signals:
//   req           [7:0] level-sensitive request vector, bit k = requester k
//   gnt_valid           a grant is active
//   gnt_idx       [2:0] index of the current owner (0 when idle)
//   gnt_onehot    [7:0] one-hot decode of gnt_idx gated by gnt_valid
//   timeout_pulse       one-cycle pulse on a forced preemption
// Modports: master = client side (drives req), slave = arbiter side.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               timeout_pulse;

    modport master (
        output req,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot,
        input  timeout_pulse
    );

    modport slave (
        input  req,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot,
        output timeout_pulse
    );

endinterface

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational rotating-priority search.
// Ports:
//   req_i   [7:0] candidate requests
//   ptr_i   [2:0] first index to examine; order is ptr, ptr+1, ..., ptr+7 mod 8
//   excl_i  [7:0] bits that may not be selected this cycle
//   found_o       at least one eligible request
//   idx_o   [2:0] first eligible index in search order (0 when none)
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic [NUM_REQ-1:0] excl_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // 3-bit addition wraps naturally modulo 8
            cand = ptr_i + IDX_W'(i);
            if (!found_o && req_i[cand] && !excl_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with registered grants.
// An owner keeps the grant while its request stays high; on release the
// pointer moves to owner+1 and the next requester is granted on that same edge.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter8_if.slave (req in; gnt_valid/gnt_idx/gnt_onehot/timeout_pulse out)
// Parameter:
//   MAX_HOLD  cycles an owner may hold before becoming preemptible (1..255)
// Optional feature macro RR_ARBITER8_TIMEOUT_EN: adds the hold counter and
// forced preemption; without it grants last until release and timeout_pulse is 0.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter8_if.slave    bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0] gnt_onehot_q, gnt_onehot_d;

    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_excl;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               preempt;
    logic               new_grant;

    // While granted, search starts after the owner and masks the owner out,
    // so a re-asserted owner bit cannot win the switch cycle.
    always_comb begin
        pick_ptr  = ptr_q;
        pick_excl = '0;
        if (state_q == GRANT) begin
            pick_ptr             = gnt_idx_q + IDX_W'(1);
            pick_excl[gnt_idx_q] = 1'b1;
        end
    end

    rr_pick8 u_pick (
        .req_i   (bus.req),
        .ptr_i   (pick_ptr),
        .excl_i  (pick_excl),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_req = bus.req[gnt_idx_q];

`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pulse_q, pulse_d;

    assign preempt = (state_q == GRANT) && owner_req && pick_found && (hold_q == HOLD_MAX);

    always_comb begin
        hold_d  = hold_q;
        pulse_d = preempt;
        if (new_grant || (state_d == IDLE)) begin
            hold_d = '0;
        end else if ((state_q == GRANT) && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.timeout_pulse = pulse_q;
`else
    assign preempt           = 1'b0;
    assign bus.timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        new_grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = pick_idx;
                    new_grant   = 1'b1;
                end
            end
            GRANT: begin
                // Preemption is handled exactly like a release
                if (!owner_req || preempt) begin
                    ptr_d = gnt_idx_q + IDX_W'(1);
                    if (pick_found) begin
                        gnt_idx_d = pick_idx;
                        new_grant = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                        gnt_idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        gnt_onehot_d = gnt_valid_d ? (NUM_REQ'(1) << gnt_idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
        end
    end

    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.gnt_idx    = gnt_idx_q;
    assign bus.gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8 (MAX_HOLD=4). Expected grants are
// hand-derived from the round-robin rules; timeout expectations follow
// whether RR_ARBITER8_TIMEOUT_EN is defined for the build.
module tb_rr_arbiter8;

`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input bit v, input int unsigned idx, input bit p);
        logic [2:0] eidx;
        logic [7:0] eoh;
        eidx = v ? 3'(idx) : 3'd0;
        eoh  = v ? (8'd1 << eidx) : 8'd0;
        total++;
        assert (bus.gnt_valid === v) else begin
            bad++;
            $error("FAIL %s valid got=%b exp=%b", tag, bus.gnt_valid, v);
        end
        total++;
        assert (bus.gnt_idx === eidx) else begin
            bad++;
            $error("FAIL %s idx got=%0d exp=%0d", tag, bus.gnt_idx, eidx);
        end
        total++;
        assert (bus.gnt_onehot === eoh) else begin
            bad++;
            $error("FAIL %s onehot got=%h exp=%h", tag, bus.gnt_onehot, eoh);
        end
        total++;
        assert (bus.timeout_pulse === p) else begin
            bad++;
            $error("FAIL %s pulse got=%b exp=%b", tag, bus.timeout_pulse, p);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        #7;
        check("reset", 1'b0, 0, 1'b0);
        #5 rst_n = 1'b1;

        // single request, then release -> idle with ptr=3
        bus.req = 8'b0000_0100;
        step(); check("single_grant2", 1'b1, 2, 1'b0);
        bus.req = 8'h00;
        step(); check("release_idle", 1'b0, 0, 1'b0);
        // ptr=3 so bit 3 beats bit 0
        bus.req = 8'b0000_1001;
        step(); check("ptr3_pick3", 1'b1, 3, 1'b0);
        step(); check("hold3", 1'b1, 3, 1'b0);

        // async reset mid-grant, no clock edge involved
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 0, 1'b0);
        bus.req = 8'h80;
        #1 rst_n = 1'b1;
        step(); check("post_reset_grant7", 1'b1, 7, 1'b0);
        bus.req = 8'h00;
        step(); check("release7_idle", 1'b0, 0, 1'b0);

        // all requests: 0,1,...,7,0 with each owner dropping its bit
        bus.req = 8'hFF;
        step(); check("all_first0", 1'b1, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] m;
            m = 8'd1 << k;
            bus.req = 8'hFF & ~m;
            step(); check($sformatf("rotate_from%0d", k), 1'b1, (k + 1) % 8, 1'b0);
        end
        bus.req = 8'h00;
        step(); check("rotate_end_idle", 1'b0, 0, 1'b0);

        // reach ptr=6 via grant 5, then wrap 6 -> 0
        bus.req = 8'h20;
        step(); check("grant5", 1'b1, 5, 1'b0);
        bus.req = 8'h00;
        step(); check("release5", 1'b0, 0, 1'b0);
        bus.req = 8'b0100_0001;
        step(); check("ptr6_pick6", 1'b1, 6, 1'b0);
        bus.req = 8'b0000_0001;
        step(); check("wrap_to0", 1'b1, 0, 1'b0);
        bus.req = 8'h00;
        step(); check("release0", 1'b0, 0, 1'b0);

        // owner 1 alone holds indefinitely
        bus.req = 8'h02;
        step(); check("grant1", 1'b1, 1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step(); check($sformatf("hold1_c%0d", c), 1'b1, 1, 1'b0);
        end
        // req[5] appears with the counter saturated
        bus.req = 8'h22;
        step(); check("contend", 1'b1, TO_EN ? 5 : 1, TO_EN);
        for (int c = 0; c < 3; c++) begin
            step(); check($sformatf("after_contend%0d", c), 1'b1, TO_EN ? 5 : 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares a single downstream resource, such as a bus or a memory port, among up to eight clients. It is the block that drives the enable and select inputs of the team's 3-to-8 one-hot decode logic. It outputs a registered 3-bit grant index plus the matching decoded one-hot grant vector. Owners keep the resource for as long as they hold their request. An optional hold-timeout forces fairness.

## Interface
- MAX_HOLD, 16: cycles an owner may hold before it becomes preemptible (legal 1..255; used only with timeout compiled in).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  8  request vector, level-sensitive; bit k = requester k.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  3  index of current owner; 0 when gnt_valid=0.
- gnt_onehot  out  8  one-hot decode of gnt_idx gated by gnt_valid; all-zero when idle.
- timeout_pulse  out  1  one-cycle pulse on a forced preemption.

## Operation
- State machine: IDLE, GRANT.
- Rotating pointer ptr[2:0]. Reset value 0. Search order: ptr, ptr+1, …, ptr+7, modulo 8.
- IDLE: if req≠0, grant the first set bit in search order and go to GRANT. Otherwise stay in IDLE.
- GRANT, owner's req still high: hold the grant unchanged.
- GRANT, owner's req low:
  - Set ptr = owner+1 mod 8 (7 wraps to 0).
  - If any other req bit is set, switch straight to the next owner with no idle cycle and stay in GRANT.
  - Otherwise deassert all grant outputs and go to IDLE.
- The owner's own bit is never re-selected in the same switch cycle, even if it is re-asserted.
- Hold counter hold_cnt[7:0]:
  - Cleared on every new grant.
  - Increments each cycle in GRANT.
  - Saturates at MAX_HOLD.
- gnt_onehot[k] = gnt_valid && gnt_idx==k, always.
- Asynchronous reset, at any time and including mid-grant, clears the following immediately: state=IDLE, ptr=0, hold_cnt=0, gnt_valid=0, gnt_idx=0, gnt_onehot=0, timeout_pulse=0.

## Timing
- All outputs are registered.
- req is sampled on the rising clk edge. The resulting grant is visible after that edge, so latency is 1 cycle from req to gnt_valid.
- Release-to-next-grant is 1 cycle. The next owner's grant appears on the edge that samples the owner's req low.
- In steady state, a requester waits at most 7 grant tenures. With timeout enabled, each tenure is bounded by MAX_HOLD+1 cycles.
- All eight requests asserted from reset: grants go in the order 0,1,…,7,0 as each owner drops its req.

## Configuration
- Macro: RR_ARBITER8_TIMEOUT_EN.
- Defined:
  - When hold_cnt==MAX_HOLD while the owner's req is still high and any other req bit is set, the arbiter preempts.
  - Preemption behaves exactly as a release: ptr = owner+1, and the next owner is granted on that edge.
  - timeout_pulse is high for that one cycle.
  - If no other req bit is set, the owner keeps the grant with the counter saturated, and preemption happens on the first cycle another req appears.
- Undefined:
  - No hold counter is present.
  - Grants last until release.
  - timeout_pulse is tied to 0.
  - MAX_HOLD is ignored.

## Structure
- Package arb_pkg: localparams NUM_REQ=8, IDX_W=3, CNT_W=8, and the state enum {IDLE, GRANT}.
- Sub-module rr_pick8: combinational. Inputs are req[7:0], ptr[2:0] and an exclude mask. Outputs are found and idx[2:0]. This is the rotating priority search.
- The top level holds the FSM, ptr, hold counter, output registers and one-hot decode.

## Test plan
- Reset then req=8'b0000_0100 → gnt_valid=1, gnt_idx=2, gnt_onehot=8'h04 one cycle later. Drop req → all outputs 0 next cycle, ptr=3.
- req=8'hFF held, each owner drops its bit for one cycle after being granted → grant sequence 0..7 then 0, with no idle gap between owners.
- ptr=6, req=8'b0100_0001 → grant 6. On release → grant 0 (wrap) on the next edge.
- Async reset asserted mid-grant without a clock edge → all outputs 0 immediately. After deassert with req=8'h80 → grant 7.
- With RR_ARBITER8_TIMEOUT_EN and MAX_HOLD=4: req[1] held, req[5] raised → preempt to 5 after hold_cnt reaches 4, with timeout_pulse high for exactly 1 cycle. With only req[1] set, it holds indefinitely.
- Without the macro: same stimulus → owner 1 holds indefinitely and timeout_pulse stays 0.
